wb_timer_bank: RTL and testbench

Parametrised bank of `CHANNELS` independent `BITS`-wide counter/timer channels behind a single Wishbone slave port in the user project area.
- Each channel counts up or down, periodic or one-shot, against a programmable compare value.
- Each channel raises a sticky match flag, a one-cycle event pulse and a maskable interrupt.
- Channel 0's count drives the GPIO bus.
- The block generalises the single free-running counter to multiple channels, direction, modes and interrupts.

---
 rtl/wb_timer_bank.sv | 135 +++++++++++++
 tb/tb_wb_timer_bank.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer_bank.sv
// Bank of CHANNELS up/down, periodic/one-shot counter channels behind one Wishbone slave.
// Each channel has a sticky MATCH flag, a one-cycle event pulse and a maskable interrupt.
module wb_timer_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned BITS     = 32
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic [CHANNELS-1:0] evt_o,
  output logic                irq_o,
  output logic [BITS-1:0]     count0_o
);

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;

  logic [BITS-1:0]     count_q   [CHANNELS];
  logic [BITS-1:0]     compare_q [CHANNELS];
  logic [CHANNELS-1:0] en_q, dir_q, mode_q, irq_en_q, match_q, evt_q;
  logic                ack_q;
  logic [31:0]         dat_q;

  logic                start, wr;
  logic [3:0]          ch_sel;
  logic [1:0]          reg_sel;
  logic [31:0]         rdata;
  logic [CHANNELS-1:0] wr_ctrl, wr_count, wr_cmp, wr_stat, term;
  logic                unused_ok;

  assign start     = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr        = start & wbs_we_i;
  assign ch_sel    = wbs_adr_i[7:4];
  assign reg_sel   = wbs_adr_i[3:2];
  assign unused_ok = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign evt_o     = evt_q;
  assign irq_o     = |(match_q & irq_en_q);
  assign count0_o  = count_q[0];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? din[8*b +: 8] : old[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode, read mux and terminal detection; unmapped channels never match a slot.
  always_comb begin
    wr_ctrl  = '0;
    wr_count = '0;
    wr_cmp   = '0;
    wr_stat  = '0;
    term     = '0;
    rdata    = 32'd0;
    for (int n = 0; n < CHANNELS; n++) begin
      term[n] = dir_q[n] ? (count_q[n] == '0) : (count_q[n] == compare_q[n]);
      if (ch_sel == 4'(n)) begin
        wr_ctrl[n]  = wr && (reg_sel == REG_CTRL);
        wr_count[n] = wr && (reg_sel == REG_COUNT);
        wr_cmp[n]   = wr && (reg_sel == REG_COMPARE);
        wr_stat[n]  = wr && (reg_sel == 2'd3);
        case (reg_sel)
          REG_CTRL:    rdata = {28'd0, irq_en_q[n], mode_q[n], dir_q[n], en_q[n]};
          REG_COUNT:   rdata = 32'(count_q[n]);
          REG_COMPARE: rdata = 32'(compare_q[n]);
          default:     rdata = {31'd0, match_q[n]};
        endcase
      end
    end
  end

  // Later assignments win: software writes override counting, reload and auto-clear.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      en_q     <= '0;
      dir_q    <= '0;
      mode_q   <= '0;
      irq_en_q <= '0;
      match_q  <= '0;
      evt_q    <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        count_q[n]   <= '0;
        compare_q[n] <= '0;
      end
    end else begin
      ack_q <= start;
      dat_q <= start ? rdata : 32'd0;
      for (int n = 0; n < CHANNELS; n++) begin
        evt_q[n] <= en_q[n] & term[n];
        if (en_q[n] && term[n]) begin
          match_q[n] <= 1'b1;
        end else if (wr_stat[n] && wbs_sel_i[0] && wbs_dat_i[0]) begin
          match_q[n] <= 1'b0;
        end
        if (en_q[n]) begin
          if (!term[n]) begin
            count_q[n] <= dir_q[n] ? count_q[n] - BITS'(1) : count_q[n] + BITS'(1);
          end else if (!mode_q[n]) begin
            count_q[n] <= dir_q[n] ? compare_q[n] : '0;
          end else begin
            en_q[n] <= 1'b0;
          end
        end
        if (wr_count[n]) begin
          count_q[n] <= BITS'(merge(32'(count_q[n]), wbs_dat_i, wbs_sel_i));
        end
        if (wr_cmp[n]) begin
          compare_q[n] <= BITS'(merge(32'(compare_q[n]), wbs_dat_i, wbs_sel_i));
        end
        if (wr_ctrl[n] && wbs_sel_i[0]) begin
          en_q[n]     <= wbs_dat_i[0];
          dir_q[n]    <= wbs_dat_i[1];
          mode_q[n]   <= wbs_dat_i[2];
          irq_en_q[n] <= wbs_dat_i[3];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_timer_bank.sv
// Self-checking bench for wb_timer_bank: register table, directed timing corners,
// randomized channel programs checked against a closed-form count model, and a BITS=8 instance.
module tb_wb_timer_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] adr = 32'd0, dat_w = 32'd0;
  logic        tgt = 1'b0;

  logic        ack_a, irq_a, ack_b, irq_b;
  logic [31:0] dat_a, dat_b, cnt_a;
  logic [3:0]  evt_a;
  logic [1:0]  evt_b;
  logic [7:0]  cnt_b;
  logic        stb_a, stb_b;

  int tests = 0;
  int failed = 0;
  int edges = 0;
  int edge_g;
  logic [31:0] rd_g, cap_evt;
  logic        cap_irq;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  assign stb_a = stb & ~tgt;
  assign stb_b = stb & tgt;

  wb_timer_bank #(.CHANNELS(4), .BITS(32)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb_a), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack_a),
    .wbs_dat_o(dat_a), .evt_o(evt_a), .irq_o(irq_a), .count0_o(cnt_a));

  wb_timer_bank #(.CHANNELS(2), .BITS(8)) dut8 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb_b), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack_b),
    .wbs_dat_o(dat_b), .evt_o(evt_b), .irq_o(irq_b), .count0_o(cnt_b));

  typedef struct {
    int          ch;
    int          rg;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one transfer from a negedge; the ack must follow one edge later and last one cycle.
  task automatic xfer(input bit w, input int ch, input int rg, input logic [31:0] d,
                      input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = 32'(ch * 16 + rg * 4); dat_w = d; sel = s;
    @(posedge clk); @(negedge clk);
    edge_g  = edges;
    check("ack_high", 32'(tgt ? ack_b : ack_a), 32'd1);
    rd_g    = tgt ? dat_b : dat_a;
    cap_irq = tgt ? irq_b : irq_a;
    cap_evt = tgt ? 32'(evt_b) : 32'(evt_a);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ack_once", 32'(tgt ? ack_b : ack_a), 32'd0);
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d);
    xfer(1'b1, ch, rg, d, 4'hF);
  endtask

  task automatic rdchk(input string name, input int ch, input int rg, input logic [31:0] exp);
    xfer(1'b0, ch, rg, 32'd0, 4'hF);
    check(name, rd_g, exp);
  endtask

  task automatic idle_to(input int target);
    while (edges < target) begin
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  // Count after m enabled edges from count c, compare k (c <= k), from the channel rules.
  function automatic void predict(input longint c, input longint k, input bit dn, input bit os,
                                  input longint m, output longint cnt, output bit en,
                                  output bit mt);
    longint hit;
    hit = dn ? c + 1 : k - c + 1;
    mt  = (m >= hit);
    en  = !(os && m >= hit);
    if (m < hit)   cnt = dn ? c - m : c + m;
    else if (os)   cnt = dn ? 0 : k;
    else           cnt = dn ? k - ((m - hit) % (k + 1)) : (m - hit) % (k + 1);
  endfunction

  initial begin
    longint cnt, k, c, m;
    bit en, mt, dn, os, ie;
    int e, ch, n;

    vecs[0] = '{0, 2, 32'hAABBCCDD, 4'b0101, 32'h00BB00DD};
    vecs[1] = '{1, 2, 32'h12345678, 4'b1111, 32'h12345678};
    vecs[2] = '{3, 1, 32'hFFFFFFFF, 4'b1000, 32'hFF000000};
    vecs[3] = '{2, 0, 32'hFFFFFFFE, 4'b1111, 32'h0000000E};
    vecs[4] = '{4, 2, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
    vecs[5] = '{15, 1, 32'h12345678, 4'b1111, 32'h00000000};
    vecs[6] = '{0, 0, 32'h0000FF0F, 4'b0010, 32'h00000000};
    vecs[7] = '{3, 3, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
    vecs[8] = '{0, 2, 32'h00000000, 4'b0000, 32'h00BB00DD};

    // Reset state
    do_reset();
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_dat", dat_a, 32'd0);
    check("rst_evt", 32'(evt_a), 32'd0);
    check("rst_irq", 32'(irq_a), 32'd0);
    check("rst_cnt0", cnt_a, 32'd0);
    check("rst_cnt0_b8", 32'(cnt_b), 32'd0);
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 4; r++)
        rdchk($sformatf("rst_reg_ch%0d_r%0d", i, r), i, r, 32'd0);

    // Reset at the valid edge aborts the write and produces no ack
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h08; dat_w = 32'h55; sel = 4'hF; rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_ack", 32'(ack_a), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    rdchk("abort_nowrite", 0, 2, 32'd0);

    // Register table: byte strobes, width, out-of-range channels
    for (int i = 0; i < 9; i++) begin
      xfer(1'b1, vecs[i].ch, vecs[i].rg, vecs[i].d, vecs[i].s);
      rdchk($sformatf("vec%0d", i), vecs[i].ch, vecs[i].rg, vecs[i].exp);
    end

    // Periodic up on ch1, COMPARE=3
    do_reset();
    wr(1, 2, 3);
    wr(1, 0, 1);
    e = edge_g;
    for (int i = 0; i < 12; i++) begin
      m = longint'(edges - e);
      check($sformatf("per_evt_m%0d", m), 32'(evt_a[1]), 32'((m >= 4) && ((m - 4) % 4 == 0)));
      check("per_irq", 32'(irq_a), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 1, 1, 32'd0, 4'hF);
      predict(0, 3, 1'b0, 1'b0, longint'(edge_g - 1 - e), cnt, en, mt);
      check("per_count", rd_g, 32'(cnt));
    end
    rdchk("per_match", 1, 3, 32'd1);
    wr(1, 0, 0);

    // One-shot down with interrupt on ch2
    wr(2, 1, 5);
    wr(2, 0, 32'hF);
    e = edge_g;
    idle_to(e + 5);
    check("os_evt_before", 32'(evt_a[2]), 32'd0);
    idle_to(e + 6);
    check("os_evt", 32'(evt_a[2]), 32'd1);
    check("os_irq_rise", 32'(irq_a), 32'd1);
    idle_to(e + 7);
    check("os_evt_after", 32'(evt_a[2]), 32'd0);
    rdchk("os_ctrl", 2, 0, 32'hE);
    rdchk("os_match", 2, 3, 32'd1);
    rdchk("os_count", 2, 1, 32'd0);
    check("os_irq_held", 32'(irq_a), 32'd1);
    wr(2, 3, 1);
    check("os_irq_clear", 32'(cap_irq), 32'd0);

    // COUNT write coinciding with terminal on ch0
    wr(0, 2, 7);
    wr(0, 0, 1);
    e = edge_g;
    idle_to(e + 7);
    check("col_count0", cnt_a, 32'd7);
    wr(0, 1, 32'h10);
    check("col_evt", cap_evt & 32'd1, 32'd1);
    xfer(1'b0, 0, 1, 32'd0, 4'hF);
    check("col_count", rd_g, 32'h10 + 32'(edge_g - 1 - (e + 8)));
    rdchk("col_match", 0, 3, 32'd1);
    wr(0, 0, 0);

    // W1C colliding with a new match (COMPARE=0 matches every cycle)
    wr(3, 2, 0);
    wr(3, 0, 1);
    wr(3, 3, 1);
    check("w1c_evt", (cap_evt >> 3) & 32'd1, 32'd1);
    rdchk("w1c_kept", 3, 3, 32'd1);
    wr(3, 0, 0);
    wr(3, 3, 1);
    rdchk("w1c_cleared", 3, 3, 32'd0);

    // Randomized channel programs against the closed-form model
    do_reset();
    for (int t = 0; t < 30; t++) begin
      ch = int'($urandom_range(0, 3));
      k  = longint'($urandom_range(0, 12));
      c  = longint'($urandom_range(0, 32'(k)));
      dn = 1'($urandom_range(0, 1));
      os = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      wr(ch, 2, 32'(k));
      wr(ch, 1, 32'(c));
      wr(ch, 0, {28'd0, ie, os, dn, 1'b1});
      e = edge_g;
      n = int'($urandom_range(0, 30));
      repeat (n) begin
        @(posedge clk); @(negedge clk);
      end
      predict(c, k, dn, os, longint'(edges - e), cnt, en, mt);
      check($sformatf("rnd%0d_irq", t), 32'(irq_a), 32'(ie & mt));
      xfer(1'b0, ch, 1, 32'd0, 4'hF);
      predict(c, k, dn, os, longint'(edge_g - 1 - e), cnt, en, mt);
      check($sformatf("rnd%0d_count", t), rd_g, 32'(cnt));
      xfer(1'b0, ch, 3, 32'd0, 4'hF);
      predict(c, k, dn, os, longint'(edge_g - 1 - e), cnt, en, mt);
      check($sformatf("rnd%0d_match", t), rd_g, 32'(mt));
      xfer(1'b0, ch, 0, 32'd0, 4'hF);
      predict(c, k, dn, os, longint'(edge_g - 1 - e), cnt, en, mt);
      check($sformatf("rnd%0d_ctrl", t), rd_g, {28'd0, ie, os, dn, en});
      wr(ch, 0, 0);
      wr(ch, 3, 1);
    end

    // BITS=8 instance: width, reload at 0xFF, modulo wrap, down from 0
    do_reset();
    tgt = 1'b1;
    wr(0, 1, 32'hFFFFFF12);
    rdchk("b8_width", 0, 1, 32'h12);
    wr(0, 2, 32'hFF);
    wr(0, 1, 32'hFD);
    wr(0, 0, 1);
    e = edge_g;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 0, 1, 32'd0, 4'hF);
      predict(32'hFD, 32'hFF, 1'b0, 1'b0, longint'(edge_g - 1 - e), cnt, en, mt);
      check("b8_reload_up", rd_g, 32'(cnt));
    end
    wr(0, 0, 0);
    wr(0, 2, 5);
    wr(0, 1, 32'hFE);
    wr(0, 0, 1);
    e = edge_g;
    for (int i = 0; i < 2; i++) begin
      xfer(1'b0, 0, 1, 32'd0, 4'hF);
      check("b8_wrap", rd_g, (32'hFE + 32'(edge_g - 1 - e)) & 32'hFF);
    end
    wr(0, 0, 0);
    wr(1, 2, 32'hFF);
    wr(1, 1, 0);
    wr(1, 0, 3);
    e = edge_g;
    check("b8_down_evt", 32'(evt_b[1]), 32'd1);
    xfer(1'b0, 1, 1, 32'd0, 4'hF);
    predict(0, 32'hFF, 1'b1, 1'b0, longint'(edge_g - 1 - e), cnt, en, mt);
    check("b8_down_reload", rd_g, 32'(cnt));
    wr(2, 2, 32'hFF);
    rdchk("b8_range", 2, 2, 32'd0);
    tgt = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
